// File: rtl/alu_exec_unit.sv
// Multi-cycle EX-stage ALU: one-cycle arithmetic/logic, iterative shifts and count-trailing-zeros.
// Build option: define FAST_SHIFT_EN to use a one-cycle barrel shifter instead of the iterative one.
module alu_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);
    localparam int SHAMT_W = $clog2(XLEN);
    localparam int CNT_W   = SHAMT_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_FULL = {1'b1, {SHAMT_W{1'b0}}};

    localparam logic [3:0] OP_OR   = 4'b0000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SRL  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRA  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_AND  = 4'b1100;
    localparam logic [3:0] OP_CTZ  = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [XLEN-1:0]   work_q, work_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              zero_q, zero_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic              in_ready_s;
    logic              accept_s;
    logic              iter_shift_s;
    logic              is_shift_s;

    // Result of every op that completes on the accept edge.
    function automatic logic [XLEN-1:0] single_cycle_result(input logic [3:0]      ctrl,
                                                            input logic [XLEN-1:0] a,
                                                            input logic [XLEN-1:0] b);
        logic [XLEN-1:0] r;
`ifdef FAST_SHIFT_EN
        logic [SHAMT_W-1:0] sh;
        sh = b[SHAMT_W-1:0];
`endif
        r = '0;
        case (ctrl)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_SLT:  r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
            OP_XOR:  r = a ^ b;
            OP_OR:   r = a | b;
            OP_AND:  r = a & b;
`ifdef FAST_SHIFT_EN
            OP_SLL:  r = a << sh;
            OP_SRL:  r = a >> sh;
            OP_SRA:  r = $unsigned($signed(a) >>> sh);
`else
            // Iterative build only gets here with a zero shift amount.
            OP_SLL, OP_SRL, OP_SRA: r = a;
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

    // One bit-step of the iterative shifter.
    function automatic logic [XLEN-1:0] shift_step(input logic [3:0] ctrl, input logic [XLEN-1:0] w);
        logic [XLEN-1:0] r;
        case (ctrl)
            OP_SLL:  r = {w[XLEN-2:0], 1'b0};
            OP_SRL:  r = {1'b0, w[XLEN-1:1]};
            OP_SRA:  r = {w[XLEN-1], w[XLEN-1:1]};
            default: r = w;
        endcase
        return r;
    endfunction

    // Handshake decode and choice of iterative vs one-cycle path.
    always_comb begin
        in_ready_s = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
        accept_s   = in_valid && in_ready_s;
        is_shift_s = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA);
`ifdef FAST_SHIFT_EN
        iter_shift_s = 1'b0;
`else
        iter_shift_s = is_shift_s && (op_b[SHAMT_W-1:0] != {SHAMT_W{1'b0}});
`endif
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        work_d   = work_q;
        count_d  = count_q;
        result_d = result_q;
        zero_d   = zero_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept_s) begin
                    op_d = alu_ctrl;
                    if (iter_shift_s) begin
                        state_d = S_BUSY;
                        work_d  = op_a;
                        count_d = {1'b0, op_b[SHAMT_W-1:0]};
                    end else if ((alu_ctrl == OP_CTZ) && !op_a[0]) begin
                        // Bit 0 is already known clear, so the scan starts at bit 1.
                        state_d = S_BUSY;
                        work_d  = {1'b0, op_a[XLEN-1:1]};
                        count_d = CNT_ONE;
                    end else begin
                        state_d  = S_DONE;
                        result_d = single_cycle_result(alu_ctrl, op_a, op_b);
                        zero_d   = (result_d == {XLEN{1'b0}});
                    end
                end else if (state_q == S_DONE && out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            S_BUSY: begin
                if (op_q == OP_CTZ) begin
                    if (work_q[0] || (count_q == CNT_FULL)) begin
                        state_d  = S_DONE;
                        result_d = {{(XLEN-CNT_W){1'b0}}, count_q};
                        zero_d   = 1'b0;
                    end else begin
                        work_d  = {1'b0, work_q[XLEN-1:1]};
                        count_d = count_q + CNT_ONE;
                    end
                end else begin
                    work_d  = shift_step(op_q, work_q);
                    count_d = count_q - CNT_ONE;
                    if (count_q == CNT_ONE) begin
                        state_d  = S_DONE;
                        result_d = work_d;
                        zero_d   = (work_d == {XLEN{1'b0}});
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d == S_BUSY);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= 4'b0000;
            work_q      <= '0;
            count_q     <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            work_q      <= work_d;
            count_q     <= count_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign result    = result_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized bench for alu_exec_unit: behavioural result/latency model plus directed literal cases.
module tb_alu_exec_unit;
    localparam int XLEN = 32;
`ifdef FAST_SHIFT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    localparam logic [3:0] C_OR = 4'b0000, C_SLL = 4'b0001, C_ADD = 4'b0010, C_SRL = 4'b0011;
    localparam logic [3:0] C_XOR = 4'b0100, C_SRA = 4'b0101, C_SUB = 4'b0110, C_SLT = 4'b0111;
    localparam logic [3:0] C_SLTU = 4'b1000, C_AND = 4'b1100, C_CTZ = 4'b1111;
    localparam logic [3:0] C_BAD1 = 4'b1010, C_BAD2 = 4'b1110;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  alu_ctrl = 4'b0000;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    int n_pass = 0;
    int n_total = 0;

    // Model: one op in flight, becoming visible at cycle m_ready_cyc.
    bit          m_active = 1'b0;
    int          cyc = 0;
    int          m_ready_cyc = 0;
    logic [31:0] m_res = 32'd0;
    bit          m_acc;
    bit          m_cons;

    logic [3:0]  codes [13] = '{C_ADD, C_SUB, C_SLT, C_SLTU, C_SLL, C_SRL, C_SRA,
                                C_XOR, C_OR, C_AND, C_CTZ, C_BAD1, C_BAD2};

    alu_exec_unit #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic int ctz32(input logic [31:0] v);
        int n;
        n = 0;
        while (n < 32 && !v[n]) n++;
        return n;
    endfunction

    function automatic logic [31:0] ref_result(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            C_ADD:   return a + b;
            C_SUB:   return a - b;
            C_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            C_SLTU:  return (a < b) ? 32'd1 : 32'd0;
            C_SLL:   return a << b[4:0];
            C_SRL:   return a >> b[4:0];
            C_SRA:   return $unsigned($signed(a) >>> b[4:0]);
            C_XOR:   return a ^ b;
            C_OR:    return a | b;
            C_AND:   return a & b;
            C_CTZ:   return 32'(ctz32(a));
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            C_SLL, C_SRL, C_SRA: return FAST ? 1 : int'(b[4:0]) + 1;
            C_CTZ:               return ctz32(a) + 1;
            default:             return 1;
        endcase
    endfunction

    function automatic bit exp_out_valid();
        return m_active && (cyc >= m_ready_cyc);
    endfunction

    function automatic bit exp_busy();
        return m_active && (cyc < m_ready_cyc);
    endfunction

    function automatic bit exp_in_ready();
        return !m_active || (exp_out_valid() && out_ready);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    // Model update on each edge, using inputs held stable since the previous edge.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_active = 1'b0;
            cyc = 0;
            m_ready_cyc = 0;
            m_res = 32'd0;
        end else begin
            m_acc  = in_valid && exp_in_ready();
            m_cons = exp_out_valid() && out_ready;
            if (m_acc) begin
                m_active    = 1'b1;
                m_ready_cyc = cyc + ref_latency(alu_ctrl, op_a, op_b);
                m_res       = ref_result(alu_ctrl, op_a, op_b);
            end else if (m_cons) begin
                m_active = 1'b0;
            end
            cyc = cyc + 1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_out_valid()});
        chk("busy", {31'd0, busy}, {31'd0, exp_busy()});
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_in_ready()});
        if (exp_out_valid()) begin
            chk("result", result, m_res);
            chk("zero", {31'd0, zero}, {31'd0, m_res == 32'd0});
        end
    end

    task automatic directed(input string name, input logic [3:0] c, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] er, input int el);
        int lat;
        chk({name, "_model_res"}, ref_result(c, a, b), er);
        chk({name, "_model_lat"}, ref_latency(c, a, b), el);
        @(posedge clk); #1;
        in_valid = 1'b1; alu_ctrl = c; op_a = a; op_b = b; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; op_a = $urandom; op_b = $urandom;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, "_lat"}, lat, el);
        chk({name, "_res"}, result, er);
        chk({name, "_zero"}, {31'd0, zero}, {31'd0, er == 32'd0});
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_result", result, 32'd0);
        chk("reset_zero", {31'd0, zero}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

        directed("add", C_ADD, 32'd5, 32'd7, 32'd12, 1);
        directed("sub", C_SUB, 32'd3, 32'd3, 32'd0, 1);
        directed("slt", C_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
        directed("sltu", C_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
        directed("bad1010", C_BAD1, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1);
        directed("sra4", C_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, FAST ? 1 : 5);
        directed("sll31", C_SLL, 32'd1, 32'd31, 32'h8000_0000, FAST ? 1 : 32);
        directed("srl0", C_SRL, 32'h8000_0000, 32'd0, 32'h8000_0000, 1);
        directed("ctz256", C_CTZ, 32'h0000_0100, 32'd0, 32'd8, 9);
        directed("ctz0", C_CTZ, 32'd0, 32'd0, 32'd32, 33);
        directed("ctz1", C_CTZ, 32'd1, 32'd0, 32'd0, 1);

        // Backpressure, then back-to-back accept in the releasing cycle.
        @(posedge clk); #1;
        in_valid = 1'b1; alu_ctrl = C_ADD; op_a = 32'd5; op_b = 32'd7; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("bp_result", result, 32'd12);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b1; alu_ctrl = C_SUB; op_a = 32'd3; op_b = 32'd3; out_ready = 1'b1;
        #1 chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        chk("bp_next_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_next_res", result, 32'd0);
        chk("bp_next_zero", {31'd0, zero}, 32'd1);
        drain();

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            alu_ctrl  = codes[$urandom_range(0, 12)];
            op_a      = $urandom;
            op_b      = $urandom;
            if (alu_ctrl == C_CTZ) begin
                op_a = ($urandom_range(0, 7) == 0) ? 32'd0 : (op_a << $urandom_range(0, 31));
            end
            if ($urandom_range(0, 7) == 0) op_b = op_a;
        end
        drain();

        // Asynchronous reset in the middle of a long CTZ.
        @(posedge clk); #1;
        in_valid = 1'b1; alu_ctrl = C_CTZ; op_a = 32'd0; op_b = 32'd0; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drain();
        chk("rst_no_stale_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_no_stale_result", result, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
